// File: rtl/decrypt_pipe_rotor_pkg.sv
// Shared constants and helpers for the rotor decryption stage.
// Stepping is controlled by the DECRYPT_ROTOR_STEP_EN macro (see rotor_odometer).
package decrypt_pkg;

  localparam logic [7:0] ALPHA_N       = 8'd26;
  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;
  localparam int         EXT_W         = 32;
  localparam logic [5:0] EXT_BASE      = 6'd6;

  typedef struct packed {
    logic [4:0] p;
    logic       hole;
  } ext_pos_t;

  // Nine conditional subtractions cover the full 0..255 input range.
  function automatic logic [4:0] mod26(input logic [7:0] v);
    logic [7:0] t;
    t = v;
    for (int k = 0; k < 9; k++) begin
      if (t >= ALPHA_N) t = t - ALPHA_N;
    end
    return t[4:0];
  endfunction

  // Bit position of the one-hot letter in the extended word, plus the
  // single unrepresentable (a=19, s=7) combination.
  function automatic ext_pos_t ext_pos(input logic [4:0] a, input logic [2:0] s);
    logic [5:0] sum;
    ext_pos_t   r;
    sum    = {1'b0, a} + {3'b000, s} + EXT_BASE;
    r.hole = (s == 3'd7) && (a == 5'd19);
    if (sum <= 6'd31) r.p = sum[4:0];
    else              r.p = sum[4:0] - 5'd26;
    return r;
  endfunction

endpackage

// File: rtl/decrypt_pipe_rotor_odometer.sv
// Three-rotor offset store with odometer stepping.
// Stepping exists only when DECRYPT_ROTOR_STEP_EN is defined; otherwise offsets are static.
module rotor_odometer
  import decrypt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic       step,
  input  logic [2:0] rot_freq,
  output logic [4:0] r1,
  output logic [4:0] r2,
  output logic [4:0] r3
);

`ifdef DECRYPT_ROTOR_STEP_EN
  logic [2:0] cnt;
  logic [2:0] cnt_inc;
  logic       fire;

  assign cnt_inc = cnt + 3'd1;
  // rot_freq of zero never fires, even when the 3-bit counter wraps to zero.
  assign fire    = (rot_freq != 3'd0) && (cnt_inc == rot_freq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 3'd0;
      r1  <= 5'd0;
      r2  <= 5'd0;
      r3  <= 5'd0;
    end else if (key_load) begin
      cnt <= 3'd0;
      r1  <= mod26(k1);
      r2  <= mod26(k2);
      r3  <= mod26(k3);
    end else if (step) begin
      if (fire) begin
        cnt <= 3'd0;
        if (r1 == 5'd25) begin
          r1 <= 5'd0;
          if (r2 == 5'd25) begin
            r2 <= 5'd0;
            r3 <= (r3 == 5'd25) ? 5'd0 : r3 + 5'd1;
          end else begin
            r2 <= r2 + 5'd1;
          end
        end else begin
          r1 <= r1 + 5'd1;
        end
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{step, rot_freq};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1 <= 5'd0;
      r2 <= 5'd0;
      r3 <= 5'd0;
    end else if (key_load) begin
      r1 <= mod26(k1);
      r2 <= mod26(k2);
      r3 <= mod26(k3);
    end
  end
`endif

endmodule

// File: rtl/decrypt_pipe_rotor.sv
// Classifies ciphertext bytes, strips the rotor substitution and packs the pre-rotated
// one-hot word with its sideband. Stepping enabled by DECRYPT_ROTOR_STEP_EN.
module decrypt_pipe_rotor
  import decrypt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       din,
  input  logic             key_load,
  input  logic [7:0]       k1,
  input  logic [7:0]       k2,
  input  logic [7:0]       k3,
  input  logic [2:0]       rot_freq,
  input  logic             shift_en,
  input  logic [2:0]       shift_amt,
  input  logic             mode,
  output logic             en_out,
  output logic [EXT_W-1:0] extended_shift_out,
  output logic             is_alpha_upper_case,
  output logic             is_alpha_low_case,
  output logic             shift_en_out,
  output logic [2:0]       shift_amt_out,
  output logic             mode_out,
  output logic             hole_err
);

  logic [4:0]       r1, r2, r3;
  logic             upper, lower, letter_mode, accept, hole_hit;
  logic [7:0]       base, diff;
  logic [4:0]       a;
  ext_pos_t         pos;
  logic [EXT_W-1:0] ext_next;

  assign upper       = (din >= ASCII_UPPER_A) && (din <= ASCII_UPPER_A + 8'd25);
  assign lower       = (din >= ASCII_LOWER_A) && (din <= ASCII_LOWER_A + 8'd25);
  assign accept      = en && !key_load;
  assign letter_mode = mode && (upper || lower);
  assign base        = upper ? ASCII_UPPER_A : ASCII_LOWER_A;

  // 78 = 3*26 keeps the difference non-negative before the single mod-26 fold.
  assign diff = din - base + 8'd78 - {3'b000, r1} - {3'b000, r2} - {3'b000, r3};
  assign a    = mod26(diff);
  assign pos  = ext_pos(a, shift_amt);

  assign hole_hit = letter_mode && shift_en && pos.hole;

  always_comb begin
    ext_next = {24'b0, din};
    if (letter_mode) begin
      if (!shift_en)    ext_next = {24'b0, base + {3'b000, a}};
      else if (pos.hole) ext_next = {24'b0, base + 8'd19};
      else              ext_next = 32'd1 << pos.p;
    end
  end

  rotor_odometer u_odometer (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .k1       (k1),
    .k2       (k2),
    .k3       (k3),
    .step     (accept && letter_mode),
    .rot_freq (rot_freq),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3)
  );

  // Dropped or idle cycles only lower en_out; the rest of the word holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_out              <= 1'b0;
      extended_shift_out  <= '0;
      is_alpha_upper_case <= 1'b0;
      is_alpha_low_case   <= 1'b0;
      shift_en_out        <= 1'b0;
      shift_amt_out       <= 3'd0;
      mode_out            <= 1'b0;
      hole_err            <= 1'b0;
    end else begin
      en_out <= accept;
      if (key_load) hole_err <= 1'b0;
      if (accept) begin
        extended_shift_out  <= ext_next;
        is_alpha_upper_case <= letter_mode && upper;
        is_alpha_low_case   <= letter_mode && lower;
        shift_en_out        <= shift_en && !hole_hit;
        shift_amt_out       <= shift_amt;
        mode_out            <= mode;
        if (hole_hit) hole_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decrypt_pipe_rotor.sv
// Directed + random bench for decrypt_pipe_rotor with a reference model and expected queue.
module tb_decrypt_pipe_rotor;

  logic        clk, rst, en, key_load, shift_en, mode;
  logic [7:0]  din, k1, k2, k3;
  logic [2:0]  rot_freq, shift_amt;
  logic        en_out, is_alpha_upper_case, is_alpha_low_case, shift_en_out, mode_out, hole_err;
  logic [31:0] extended_shift_out;
  logic [2:0]  shift_amt_out;

  logic [39:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          m_r1, m_r2, m_r3, m_cnt;
  bit          m_hole;
  logic [31:0] obs_ext;
  logic [31:0] last_ext;

  decrypt_pipe_rotor dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .key_load(key_load),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq), .shift_en(shift_en),
    .shift_amt(shift_amt), .mode(mode), .en_out(en_out),
    .extended_shift_out(extended_shift_out), .is_alpha_upper_case(is_alpha_upper_case),
    .is_alpha_low_case(is_alpha_low_case), .shift_en_out(shift_en_out),
    .shift_amt_out(shift_amt_out), .mode_out(mode_out), .hole_err(hole_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] outputs_now();
    return {extended_shift_out, is_alpha_upper_case, is_alpha_low_case, shift_en_out,
            shift_amt_out, mode_out, hole_err};
  endfunction

  // Reference behaviour for one accepted byte; updates the model rotors.
  task automatic model(input int d, input bit md, input bit se, input int s,
                       output logic [39:0] e);
    int          base, a, p;
    bit          up, lo, let_m, seo;
    logic [31:0] ext;
    logic [2:0]  s3;
    up    = (d >= 65) && (d <= 90);
    lo    = (d >= 97) && (d <= 122);
    let_m = md && (up || lo);
    ext   = d;
    seo   = se;
    s3    = s[2:0];
    if (let_m) begin
      base = up ? 65 : 97;
      a = ((d - base - m_r1 - m_r2 - m_r3) % 26 + 26) % 26;
      if (!se) ext = base + a;
      else if (s == 7 && a == 19) begin
        ext = base + 19;
        seo = 1'b0;
        m_hole = 1'b1;
      end else begin
        p = (a + 6 + s <= 31) ? a + 6 + s : a + s - 20;
        ext = 32'h1 << p;
      end
`ifdef DECRYPT_ROTOR_STEP_EN
      m_cnt = (m_cnt + 1) % 8;
      if (rot_freq != 0 && m_cnt == int'(rot_freq)) begin
        m_cnt = 0;
        m_r1++;
        if (m_r1 == 26) begin
          m_r1 = 0;
          m_r2++;
          if (m_r2 == 26) begin
            m_r2 = 0;
            m_r3 = (m_r3 + 1) % 26;
          end
        end
      end
`endif
    end
    e = {ext, up && let_m, lo && let_m, seo, s3, md, m_hole};
  endtask

  task automatic send(input int d, input bit md, input bit se, input int s, input string tag);
    logic [39:0] e, got;
    @(negedge clk);
    en = 1'b1; din = d[7:0]; mode = md; shift_en = se; shift_amt = s[2:0];
    model(d, md, se, s, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0;
    check({tag, "_en"}, {63'b0, en_out}, 64'd1);
    if (en_out === 1'b1 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check(tag, {24'b0, outputs_now()}, {24'b0, got});
      last_ext = got[39:8];
    end
    obs_ext = extended_shift_out;
  endtask

  task automatic load_keys(input int a1, input int a2, input int a3);
    @(negedge clk);
    key_load = 1'b1; k1 = a1[7:0]; k2 = a2[7:0]; k3 = a3[7:0];
    en = 1'b1; din = 8'd90;
    @(posedge clk);
    #1;
    key_load = 1'b0; en = 1'b0;
    m_r1 = a1 % 26; m_r2 = a2 % 26; m_r3 = a3 % 26; m_cnt = 0; m_hole = 1'b0;
    check("kl_drop", {63'b0, en_out}, 64'd0);
    check("kl_hole_clr", {63'b0, hole_err}, 64'd0);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_en"}, {63'b0, en_out}, 64'd0);
    check({tag, "_hold"}, {32'b0, extended_shift_out}, {32'b0, last_ext});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; key_load = 1'b0; shift_en = 1'b0; mode = 1'b0;
    din = 8'd0; k1 = 8'd0; k2 = 8'd0; k3 = 8'd0; rot_freq = 3'd0; shift_amt = 3'd0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_cnt = 0; m_hole = 1'b0; last_ext = '0;
    #2;
    check("reset_state", {23'b0, en_out, outputs_now()}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    load_keys(0, 0, 0);
    send(65, 1, 1, 0, "basic");
    check("basic_lit", {32'b0, obs_ext}, 64'h40);

    load_keys(3, 0, 0);
    send(100, 1, 1, 2, "keyed_lower");
    check("keyed_lower_lit", {32'b0, obs_ext}, 64'h100);
    send(33, 1, 1, 2, "nonletter");
    check("nonletter_lit", {32'b0, obs_ext}, 64'h21);
    send(100, 1, 1, 2, "after_nonletter");
    check("after_nonletter_lit", {32'b0, obs_ext}, 64'h100);
    idle("idle");
    send(100, 0, 1, 2, "bypass");
    send(72, 1, 0, 5, "noshift");

    rot_freq = 3'd1;
    load_keys(25, 25, 0);
    send(65, 1, 1, 0, "odo_first");
    check("odo_first_lit", {32'b0, obs_ext}, 64'h100);
    send(65, 1, 1, 0, "odo_second");
`ifdef DECRYPT_ROTOR_STEP_EN
    check("odo_second_lit", {32'b0, obs_ext}, 64'h8000_0000);
`else
    check("odo_second_lit", {32'b0, obs_ext}, 64'h100);
`endif

    rot_freq = 3'd0;
    load_keys(0, 0, 0);
    send(84, 1, 1, 7, "hole");
    check("hole_lit", {32'b0, obs_ext}, 64'h54);
    check("hole_flag", {62'b0, hole_err, shift_en_out}, 64'b10);
    send(65, 1, 1, 0, "hole_held");
    load_keys(0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      int d;
      rot_freq = 3'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) :
          ($urandom_range(0, 1) == 0) ? int'($urandom_range(65, 90)) : int'($urandom_range(97, 122));
      send(d, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), "rand");
    end

    // Reset asserted mid-cycle while a burst is in flight.
    @(negedge clk);
    en = 1'b1; din = 8'd66; mode = 1'b1; shift_en = 1'b1; shift_amt = 3'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset", {23'b0, en_out, outputs_now()}, 64'd0);
    exp_q.delete();
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_cnt = 0; m_hole = 1'b0;
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    send(65, 1, 1, 0, "post_reset");
    check("post_reset_lit", {32'b0, obs_ext}, 64'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
